cfg_chain_loader: RTL
=====================

Name: cfg_chain_loader

Overview:
Bitstream writer for the serial configuration chains (CfgMode/CfgClk/CfgShift/CfgDataIn/CfgDataOut) used by the reconfigurable FSM and wrapper blocks. It takes 16-bit configuration words over a valid/ready handshake and shifts them LSB-first into one chain with a generated configuration clock. It also captures the chain's serial output as 16-bit readback words. It sits between the SoC peripheral bus and the chain inputs of the reconfigurable module.

Parameters:
ClkDiv, 2, Clk_i cycles per CfgClk phase (low phase = high phase = ClkDiv); legal range 1..255.
LengthWidth, 16, width of the bit-count input.

Ports:
Clk_i  input  1  system clock
Reset_n_i  input  1  asynchronous active-low reset
Start_i  input  1  one-cycle pulse; begins a load when Idle
Length_i  input  LengthWidth  total chain bits to shift; sampled on accepted Start_i
Abort_i  input  1  terminates the load immediately
Data_i  input  16  next configuration word, bit 0 shifted first
DataValid_i  input  1  Data_i valid
DataReady_o  output  1  loader accepts Data_i this cycle
ReadData_o  output  16  readback word
ReadValid_o  output  1  one-cycle pulse: ReadData_o valid
Busy_o  output  1  load in progress
Done_o  output  1  one-cycle pulse at normal completion
CfgMode_o  output  1  chain configuration mode
CfgClk_o  output  1  chain shift clock
CfgShift_o  output  1  chain shift enable
CfgDataOut_o  output  1  serial data into the chain (chain CfgDataIn_i)
CfgDataIn_i  input  1  serial data from the chain (chain CfgDataOut_o)

Behaviour:
- Single clock domain Clk_i. Reset asserts asynchronously and returns the FSM to Idle. All outputs reset to 0, including ReadData_o. Internal counters reset to 0.
- States: Idle, Setup, Fetch, Low, High, Finish.
- Idle: Start_i=1 latches Length_i into BitsLeft. If Length_i=0, Done_o pulses next cycle, no Cfg* activity, and the FSM stays Idle. Otherwise the FSM goes to Setup. Start_i in any other state is ignored.
- Setup: lasts 1 cycle with CfgMode_o=1, CfgShift_o=0. Next state is Fetch.
- Fetch: DataReady_o=1. On DataValid_i&DataReady_o, the word is loaded into the shift register, BitIdx=0, and the FSM goes to Low. While waiting, CfgClk_o stays 0 and CfgShift_o holds its current value.
- Low: lasts ClkDiv cycles.
  - CfgDataOut_o = ShiftReg[0] for the whole phase. CfgShift_o=1 from the first Low onward. CfgClk_o=0.
  - On the last Low cycle, CfgDataIn_i is sampled into ReadReg[BitIdx].
  - Then the FSM goes to High.
- High: lasts ClkDiv cycles with CfgClk_o=1, and CfgDataOut_o is held stable. At the end of the phase, BitsLeft is decremented, the shift register shifts right, and BitIdx is incremented. Then:
  - if BitsLeft becomes 0: go to Finish;
  - else if BitIdx wraps to 16: go to Fetch;
  - else: go to Low.
- Readback: ReadData_o <= ReadReg and ReadValid_o pulses 1 cycle when the 16th bit of a word is sampled, or when the final chain bit is sampled. In the final-bit case, unfilled upper bits are 0.
- A partial final word (Length mod 16 ≠ 0) has its unused upper bits discarded and never driven.
- Finish: lasts 1 cycle with CfgShift_o=0, CfgClk_o=0, CfgMode_o=1. Next cycle: CfgMode_o=0, Done_o=1 for one cycle, and the FSM returns to Idle.
- Busy_o=1 in every state except Idle.
- CfgClk_o is registered and glitch-free. Exact CfgClk rising edges equal Length_i.
- Abort_i has priority over all events. At the next edge, the FSM goes to Idle and CfgMode_o, CfgShift_o, CfgClk_o and CfgDataOut_o go to 0. No Done_o and no ReadValid_o are produced. A High phase is cut short; the chain contents are undefined.
- DataValid_i without DataReady_o is ignored; the word is not consumed.

Test Plan:
1. ClkDiv=1, Length=8, Data=0x00A5, CfgDataIn_i=0 -> CfgDataOut_o bit sequence 1,0,1,0,0,1,0,1. CfgClk_o period is 2 cycles with 8 rising edges. ReadValid_o fires once with ReadData_o=0x0000, then Done_o fires.
2. ClkDiv=2, Length=20, words 0x1234 then 0x000F. A bench chain model is a 20-bit shift register preloaded with 0xABCDE and clocked on CfgClk_o rise. Expected: 2 DataReady_o handshakes. ReadData_o=0xBCDE, then 0x000A. The chain finally holds 0xF1234.
3. Length=0 -> Done_o pulses 1 cycle after Start_i. No CfgMode_o, CfgClk_o or DataReady_o activity.
4. Length=16, DataValid_i held 0 for 10 cycles in Fetch -> CfgClk_o stays 0 and CfgMode_o stays 1. The load resumes on the valid word, with 16 edges total.
5. Abort_i pulse during the 5th High phase -> all Cfg* outputs are 0 next cycle, Busy_o=0, no Done_o. A following Start_i runs normally.
6. Reset_n_i asserted mid-shift, asynchronously between clock edges -> all outputs are 0 immediately. After release, the block is Idle and accepts Start_i.

Source files
------------

// File: rtl/cfg_chain_loader_if.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader_if
// Word-level bus between the SoC peripheral side and the configuration chain
// loader.
//   Data       16  configuration word, bit 0 is shifted into the chain first
//   DataValid   1  Data holds a word to be loaded
//   DataReady   1  loader takes Data on this cycle when DataValid is also high
//   ReadData   16  readback word captured from the chain output
//   ReadValid   1  one-cycle pulse, ReadData holds a new word
// master: the bus side that supplies words and collects readback.
// slave : the loader.
// -----------------------------------------------------------------------------
interface cfg_chain_loader_if;
    logic [15:0] Data;
    logic        DataValid;
    logic        DataReady;
    logic [15:0] ReadData;
    logic        ReadValid;

    modport master (
        output Data,
        output DataValid,
        input  DataReady,
        input  ReadData,
        input  ReadValid
    );

    modport slave (
        input  Data,
        input  DataValid,
        output DataReady,
        output ReadData,
        output ReadValid
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
// Writes 16-bit configuration words LSB-first into one serial configuration
// chain, generating the chain clock, and captures the chain's serial output
// as 16-bit readback words.
// Ports:
//   Clk_i, Reset_n_i      clock, asynchronous active-low reset
//   Start_i, Length_i     start a load of Length_i chain bits (Idle only)
//   Abort_i               stop the load at the next edge, no completion
//   bus_if (slave)        word input handshake and readback words
//   Busy_o, Done_o        load in progress / one-cycle completion pulse
//   CfgMode_o, CfgClk_o, CfgShift_o, CfgDataOut_o   chain controls
//   CfgDataIn_i           serial data coming back from the chain
// All outputs are registered; each output register is loaded with the value
// that belongs to the state being entered, so outputs line up with the state.
// -----------------------------------------------------------------------------
module cfg_chain_loader #(
    parameter int unsigned ClkDiv      = 2,
    parameter int unsigned LengthWidth = 16
) (
    input  logic                   Clk_i,
    input  logic                   Reset_n_i,
    input  logic                   Start_i,
    input  logic [LengthWidth-1:0] Length_i,
    input  logic                   Abort_i,
    cfg_chain_loader_if.slave      bus_if,
    output logic                   Busy_o,
    output logic                   Done_o,
    output logic                   CfgMode_o,
    output logic                   CfgClk_o,
    output logic                   CfgShift_o,
    output logic                   CfgDataOut_o,
    input  logic                   CfgDataIn_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_LOW    = 3'd3,
        ST_HIGH   = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [7:0]             PHASE_LAST = 8'(ClkDiv - 1);
    localparam logic [LengthWidth-1:0] LEN_ZERO   = {LengthWidth{1'b0}};
    localparam logic [LengthWidth-1:0] LEN_ONE    = {{(LengthWidth-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [LengthWidth-1:0] bits_left_q, bits_left_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             phase_cnt_q, phase_cnt_d;
    logic [15:0]            shift_q, shift_d;
    logic [15:0]            read_reg_q, read_reg_d;
    logic [15:0]            read_data_q, read_data_d;
    logic                   read_valid_q, read_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   data_ready_q, data_ready_d;
    logic                   cfg_mode_q, cfg_mode_d;
    logic                   cfg_clk_q, cfg_clk_d;
    logic                   cfg_shift_q, cfg_shift_d;
    logic                   cfg_dout_q, cfg_dout_d;
    logic                   phase_last_s;

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d      = state_q;
        bits_left_d  = bits_left_q;
        bit_idx_d    = bit_idx_q;
        phase_cnt_d  = phase_cnt_q;
        shift_d      = shift_q;
        read_reg_d   = read_reg_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        done_d       = 1'b0;
        cfg_mode_d   = cfg_mode_q;
        cfg_clk_d    = cfg_clk_q;
        cfg_shift_d  = cfg_shift_q;
        cfg_dout_d   = cfg_dout_q;
        phase_last_s = (phase_cnt_q == PHASE_LAST);

        if (Abort_i) begin
            // Abort beats every other event, including a pending handshake.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start_i) begin
                        bits_left_d = Length_i;
                        if (Length_i == LEN_ZERO) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_SETUP;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus_if.DataValid && data_ready_q) begin
                        shift_d     = bus_if.Data;
                        bit_idx_d   = 4'd0;
                        phase_cnt_d = 8'd0;
                        // Clearing here makes unfilled upper bits of a
                        // partial final word read back as 0.
                        read_reg_d  = 16'h0000;
                        state_d     = ST_LOW;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_LOW: begin
                    if (phase_last_s) begin
                        read_reg_d[bit_idx_q] = CfgDataIn_i;
                        // Word complete, or this was the last chain bit.
                        if ((bit_idx_q == 4'd15) || (bits_left_q == LEN_ONE)) begin
                            read_data_d  = read_reg_d;
                            read_valid_d = 1'b1;
                        end else begin
                            read_valid_d = 1'b0;
                        end
                        phase_cnt_d = 8'd0;
                        state_d     = ST_HIGH;
                    end else begin
                        phase_cnt_d = phase_cnt_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (phase_last_s) begin
                        bits_left_d = bits_left_q - LEN_ONE;
                        shift_d     = {1'b0, shift_q[15:1]};
                        bit_idx_d   = bit_idx_q + 4'd1;
                        phase_cnt_d = 8'd0;
                        if (bits_left_d == LEN_ZERO) begin
                            state_d = ST_FINISH;
                        end else if (bit_idx_q == 4'd15) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_LOW;
                        end
                    end else begin
                        phase_cnt_d = phase_cnt_q + 8'd1;
                    end
                end
                ST_FINISH: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Output registers take the values of the state being entered.
        case (state_d)
            ST_IDLE: begin
                cfg_mode_d  = 1'b0;
                cfg_clk_d   = 1'b0;
                cfg_shift_d = 1'b0;
                cfg_dout_d  = 1'b0;
            end
            ST_SETUP: begin
                cfg_mode_d  = 1'b1;
                cfg_clk_d   = 1'b0;
                cfg_shift_d = 1'b0;
            end
            ST_FETCH: begin
                // Shift enable keeps its value while waiting for a word.
                cfg_mode_d = 1'b1;
                cfg_clk_d  = 1'b0;
            end
            ST_LOW: begin
                cfg_mode_d  = 1'b1;
                cfg_clk_d   = 1'b0;
                cfg_shift_d = 1'b1;
                cfg_dout_d  = shift_d[0];
            end
            ST_HIGH: begin
                cfg_mode_d  = 1'b1;
                cfg_clk_d   = 1'b1;
                cfg_shift_d = 1'b1;
            end
            ST_FINISH: begin
                cfg_mode_d  = 1'b1;
                cfg_clk_d   = 1'b0;
                cfg_shift_d = 1'b0;
            end
            default: begin
                cfg_mode_d  = 1'b0;
                cfg_clk_d   = 1'b0;
                cfg_shift_d = 1'b0;
                cfg_dout_d  = 1'b0;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        data_ready_d = (state_d == ST_FETCH);
    end

    // State, datapath and output registers
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q      <= ST_IDLE;
            bits_left_q  <= LEN_ZERO;
            bit_idx_q    <= 4'd0;
            phase_cnt_q  <= 8'd0;
            shift_q      <= 16'h0000;
            read_reg_q   <= 16'h0000;
            read_data_q  <= 16'h0000;
            read_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_ready_q <= 1'b0;
            cfg_mode_q   <= 1'b0;
            cfg_clk_q    <= 1'b0;
            cfg_shift_q  <= 1'b0;
            cfg_dout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bits_left_q  <= bits_left_d;
            bit_idx_q    <= bit_idx_d;
            phase_cnt_q  <= phase_cnt_d;
            shift_q      <= shift_d;
            read_reg_q   <= read_reg_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_ready_q <= data_ready_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_clk_q    <= cfg_clk_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_dout_q   <= cfg_dout_d;
        end
    end

    assign bus_if.DataReady = data_ready_q;
    assign bus_if.ReadData  = read_data_q;
    assign bus_if.ReadValid = read_valid_q;
    assign Busy_o           = busy_q;
    assign Done_o           = done_q;
    assign CfgMode_o        = cfg_mode_q;
    assign CfgClk_o         = cfg_clk_q;
    assign CfgShift_o       = cfg_shift_q;
    assign CfgDataOut_o     = cfg_dout_q;

endmodule
